// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the 16-channel output/PWM driver.
//   PWM_CNT_W : width of the shared PWM period counter (256 steps per period)
//   NUM_CH    : number of user output channels
//   DUTY_FULL : duty code that forces a channel permanently high
//   ch_mode_e : per-channel mode derived from the enable and PWM-select bits
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_CH    = 16;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    typedef enum logic [1:0] {
        CH_OFF    = 2'd0,
        CH_STATIC = 2'd1,
        CH_PWM    = 2'd2
    } ch_mode_e;

    // The output enable dominates: a disabled channel is OFF whatever its
    // PWM-select bit says.
    function automatic ch_mode_e ch_mode(input logic en, input logic pwm_sel);
        ch_mode_e mode;
        if (!en) begin
            mode = CH_OFF;
        end else if (!pwm_sel) begin
            mode = CH_STATIC;
        end else begin
            mode = CH_PWM;
        end
        return mode;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Divides clk down to the PWM step rate. pre_cnt runs 0..CLK_DIV-1 and wraps;
// tick is high while pre_cnt sits on its last value, so the PWM counter
// advances once every CLK_DIV clocks. With CLK_DIV = 1 tick is constantly 1.
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   tick  out 1  step enable for the PWM counter (combinational from pre_cnt)
// -----------------------------------------------------------------------------
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    assign tick = (pre_cnt_q == PRE_LAST);

    // For CLK_DIV = 1 the counter is pinned at zero and tick never drops.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Sixteen-channel output driver. Each channel is off, static high, or PWM at
// a shared duty cycle. All PWM channels share one 8-bit counter, so they are
// phase-aligned. The duty value is shadowed and only taken at the 255->0 wrap
// so no period is ever truncated; enable and mode bits act on the next edge.
//   clk             in  1   system clock
//   rst_n           in  1   asynchronous active-low reset
//   en_reg_out_7_0  in  8   output enable, channels 7..0
//   en_reg_out_15_8 in  8   output enable, channels 15..8
//   en_reg_pwm_7_0  in  8   PWM mode select, channels 7..0
//   en_reg_pwm_15_8 in  8   PWM mode select, channels 15..8
//   pwm_duty_cycle  in  8   shared duty value (0xFF = always high)
//   out             out 16  registered channel outputs
//   period_start    out 1   one-clock pulse on the edge the counter wraps to 0
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    import pwm_pkg::*;

    logic                 tick;
    logic                 wrap;
    logic                 pwm_lvl;
    logic [NUM_CH-1:0]    en_all;
    logic [NUM_CH-1:0]    pwm_all;

    logic [PWM_CNT_W-1:0] pwm_cnt_q;
    logic [PWM_CNT_W-1:0] pwm_cnt_d;
    logic [PWM_CNT_W-1:0] duty_sh_q;
    logic [PWM_CNT_W-1:0] duty_sh_d;
    logic [NUM_CH-1:0]    out_q;
    logic [NUM_CH-1:0]    out_d;
    logic                 period_start_q;
    logic                 period_start_d;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign en_all  = {en_reg_out_15_8, en_reg_out_7_0};
    assign pwm_all = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // The edge on which the counter steps from 255 to 0 is the period boundary.
    assign wrap = tick && (pwm_cnt_q == {PWM_CNT_W{1'b1}});

    // 0xFF is forced fully on; a plain compare would leave a one-step low
    // glitch at count 255.
    assign pwm_lvl = (duty_sh_q == DUTY_FULL) || (pwm_cnt_q < duty_sh_q);

    always_comb begin
        pwm_cnt_d      = pwm_cnt_q;
        duty_sh_d      = duty_sh_q;
        period_start_d = 1'b0;
        out_d          = '0;

        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + PWM_CNT_W'(1);
        end

        if (wrap) begin
            duty_sh_d      = pwm_duty_cycle;
            period_start_d = 1'b1;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            case (ch_mode(en_all[i], pwm_all[i]))
                CH_OFF:    out_d[i] = 1'b0;
                CH_STATIC: out_d[i] = 1'b1;
                CH_PWM:    out_d[i] = pwm_lvl;
                default:   out_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            duty_sh_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            duty_sh_q      <= duty_sh_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: one instance at CLK_DIV=13, one at CLK_DIV=1.
// The reference model works purely from the count of clock edges since reset.
module tb_pwm_peripheral;

    localparam int D13   = 13;
    localparam int PER13 = 256 * D13;
    localparam int PER1  = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] e13 = '0, p13 = '0, e1 = '0, p1 = '0;
    logic [7:0]  duty13 = '0, duty1 = '0;
    logic [15:0] out13, out1;
    logic        ps13, ps1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(D13)) dut13 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (e13[7:0]),
        .en_reg_out_15_8 (e13[15:8]),
        .en_reg_pwm_7_0  (p13[7:0]),
        .en_reg_pwm_15_8 (p13[15:8]),
        .pwm_duty_cycle  (duty13),
        .out             (out13),
        .period_start    (ps13)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (e1[7:0]),
        .en_reg_out_15_8 (e1[15:8]),
        .en_reg_pwm_7_0  (p1[7:0]),
        .en_reg_pwm_15_8 (p1[15:8]),
        .pwm_duty_cycle  (duty1),
        .out             (out1),
        .period_start    (ps1)
    );

    // Channel behaviour straight from the rules: off / high / level at this step.
    function automatic logic [15:0] ref_out(input logic [15:0] e, input logic [15:0] p,
                                            input int step, input logic [7:0] duty);
        logic [15:0] r;
        logic lvl;
        lvl = (duty == 8'hFF) ? 1'b1 : (step < int'(duty));
        for (int i = 0; i < 16; i++) begin
            r[i] = e[i] ? (p[i] ? lvl : 1'b1) : 1'b0;
        end
        return r;
    endfunction

    // n = edges since reset release; step before edge n+1 is floor(n/D) mod 256,
    // and the duty is captured at every edge that completes 256*D cycles.
    int          n13 = 0, n1 = 0;
    logic [7:0]  dm13 = '0, dm1 = '0;
    logic [15:0] exp13 = '0, exp1 = '0;
    logic        eps13 = 1'b0, eps1 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n13 <= 0; dm13 <= '0; exp13 <= '0; eps13 <= 1'b0;
        end else begin
            exp13 <= ref_out(e13, p13, (n13 / D13) % 256, dm13);
            eps13 <= ((n13 + 1) % PER13) == 0;
            if (((n13 + 1) % PER13) == 0) dm13 <= duty13;
            n13 <= n13 + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1 <= 0; dm1 <= '0; exp1 <= '0; eps1 <= 1'b0;
        end else begin
            exp1 <= ref_out(e1, p1, n1 % 256, dm1);
            eps1 <= ((n1 + 1) % PER1) == 0;
            if (((n1 + 1) % PER1) == 0) dm1 <= duty1;
            n1 <= n1 + 1;
        end
    end

    // Returns at the negedge where the selected period_start is seen high.
    task automatic wait_ps(input bit sel1, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((sel1 ? ps1 : ps13) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out13 !== 16'h0000 || ps13 !== 1'b0) begin
            failures++;
            $display("FAIL reset_13: out=%h ps=%b required out=0000 ps=0", out13, ps13);
        end
        checks++;
        if (out1 !== 16'h0000 || ps1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_1: out=%h ps=%b required out=0000 ps=0", out1, ps1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_static();
        e13 = 16'h00FF; p13 = 16'h0000; duty13 = 8'h80;
        @(negedge clk);
        checks++;
        if (out13 !== 16'h00FF) begin
            failures++;
            $display("FAIL static_on: out=%h required 00ff", out13);
        end
        e13 = 16'h0000; p13 = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (out13 !== 16'h0000) begin
            failures++;
            $display("FAIL static_off: out=%h required 0000", out13);
        end
        // Still inside the first period, so PWM channels read low.
        e13 = 16'hFF00; p13 = 16'h0F00;
        @(negedge clk);
        checks++;
        if (out13 !== 16'hF000 || out13 !== exp13) begin
            failures++;
            $display("FAIL static_mixed: out=%h required f000 (model %h)", out13, exp13);
        end
    endtask

    task automatic test_pwm_50();
        bit ok;
        int hi, ps_cnt, ps_pos;
        e13 = 16'hFFFF; p13 = 16'hFFFF; duty13 = 8'h80;
        wait_ps(1'b0, 2 * PER13 + 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pwm50_wait: period_start not seen within %0d cycles", 2 * PER13 + 20);
        end
        hi = 0; ps_cnt = 0; ps_pos = 0;
        for (int j = 1; j <= PER13; j++) begin
            @(negedge clk);
            hi += int'(out13[0]);
            if (ps13 === 1'b1) begin ps_cnt++; ps_pos = j; end
            checks++;
            if (out13 !== exp13 || ps13 !== eps13) begin
                failures++;
                if (failures < 20)
                    $display("FAIL pwm50_cycle %0d: out=%h ps=%b required out=%h ps=%b", j, out13, ps13, exp13, eps13);
            end
        end
        checks++;
        if (hi != 1664) begin
            failures++;
            $display("FAIL pwm50_high: high=%0d required 1664", hi);
        end
        checks++;
        if (ps_cnt != 1 || ps_pos != PER13) begin
            failures++;
            $display("FAIL pwm50_period: pulses=%0d at %0d required 1 at %0d", ps_cnt, ps_pos, PER13);
        end
    endtask

    task automatic test_duty_bounds();
        bit ok;
        int hi;
        duty13 = 8'h00;
        wait_ps(1'b0, 2 * PER13 + 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL duty0_wait: period_start not seen");
        end
        hi = 0;
        for (int j = 1; j <= PER13; j++) begin
            @(negedge clk);
            hi += int'(out13[3]);
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL duty0_high: high=%0d required 0", hi);
        end
        duty13 = 8'hFF;
        wait_ps(1'b0, 2 * PER13 + 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dutyff_wait: period_start not seen");
        end
        // Window spans the next wrap, so a count-255 low step would show.
        hi = 0;
        for (int j = 1; j <= PER13 + D13; j++) begin
            @(negedge clk);
            hi += int'(out13[7]);
        end
        checks++;
        if (hi != PER13 + D13) begin
            failures++;
            $display("FAIL dutyff_high: high=%0d required %0d", hi, PER13 + D13);
        end
    endtask

    task automatic test_shadow();
        bit ok;
        int hi;
        duty13 = 8'h40;
        wait_ps(1'b0, 2 * PER13 + 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL shadow_wait: period_start not seen");
        end
        hi = 0;
        for (int j = 1; j <= PER13; j++) begin
            @(negedge clk);
            hi += int'(out13[12]);
            if (j == 10 * D13 + 1) duty13 = 8'hC0;
            checks++;
            if (out13 !== exp13) begin
                failures++;
                if (failures < 20) $display("FAIL shadow_cycle %0d: out=%h required %h", j, out13, exp13);
            end
        end
        checks++;
        if (hi != 832) begin
            failures++;
            $display("FAIL shadow_cur: high=%0d required 832", hi);
        end
        hi = 0;
        for (int j = 1; j <= PER13; j++) begin
            @(negedge clk);
            hi += int'(out13[12]);
        end
        checks++;
        if (hi != 2496) begin
            failures++;
            $display("FAIL shadow_next: high=%0d required 2496", hi);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        e13 = 16'hFFFF; p13 = 16'hFFFF; duty13 = 8'h80;
        wait_ps(1'b0, 2 * PER13 + 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_wait: period_start not seen");
        end
        repeat (100 * D13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out13 !== 16'h0000 || ps13 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: out=%h ps=%b required out=0000 ps=0", out13, ps13);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int j = 1; j <= PER13; j++) begin
            @(negedge clk);
            if (out13 !== 16'h0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_low: %0d nonzero cycles required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (out13 !== 16'hFFFF) begin
            failures++;
            $display("FAIL rstmid_resume: out=%h required ffff", out13);
        end
    endtask

    task automatic test_mixed_div1();
        bit ok;
        int even_bad, odd_hi, odd_lo;
        e1 = 16'hFFFF; p1 = 16'hAAAA; duty1 = 8'h01;
        wait_ps(1'b1, 3 * PER1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mixed_wait: period_start not seen");
        end
        even_bad = 0; odd_hi = 0; odd_lo = 0;
        for (int j = 1; j <= PER1; j++) begin
            @(negedge clk);
            if ((out1 & 16'h5555) !== 16'h5555) even_bad++;
            if ((out1 & 16'hAAAA) === 16'hAAAA) odd_hi++;
            if ((out1 & 16'hAAAA) === 16'h0000) odd_lo++;
        end
        checks++;
        if (even_bad != 0) begin
            failures++;
            $display("FAIL mixed_even: %0d bad cycles required 0", even_bad);
        end
        checks++;
        if (odd_hi != 1 || odd_lo != 255) begin
            failures++;
            $display("FAIL mixed_odd: high=%0d low=%0d required 1 and 255", odd_hi, odd_lo);
        end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 4; r++) begin
            e13 = 16'($urandom); p13 = 16'($urandom); duty13 = 8'($urandom);
            e1  = 16'($urandom); p1  = 16'($urandom); duty1  = 8'($urandom);
            len = int'($urandom_range(3000, 1000));
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                checks++;
                if (out13 !== exp13 || ps13 !== eps13) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL rand13 r%0d c%0d: out=%h ps=%b required out=%h ps=%b", r, j, out13, ps13, exp13, eps13);
                end
                checks++;
                if (out1 !== exp1 || ps1 !== eps1) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL rand1 r%0d c%0d: out=%h ps=%b required out=%h ps=%b", r, j, out1, ps1, exp1, eps1);
                end
                if ($urandom_range(63, 0) == 0) begin
                    e13 = 16'($urandom); p13 = 16'($urandom); e1 = 16'($urandom); p1 = 16'($urandom);
                end
                if ($urandom_range(99, 0) == 0) begin
                    duty13 = 8'($urandom);
                    duty1  = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm_50();
        test_duty_bounds();
        test_shadow();
        test_reset_mid();
        test_mixed_div1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
